// File: rtl/trace_feeder.sv
// Trace replay source for the cache model: buffers {last, addr} entries in a FIFO
// and issues them one per clock after a start pulse, counting issues and underruns.
module trace_feeder #(
  parameter int ADDR_W = 31,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 31
) (
  input  logic              clk_41,
  input  logic              rst_41,
  input  logic [ADDR_W-1:0] in_addr_41,
  input  logic              in_last_41,
  input  logic              in_valid_41,
  output logic              in_ready_41,
  input  logic              start_41,
  input  logic              hold_41,
  output logic [ADDR_W-1:0] adder_41,
  output logic              adder_valid_41,
  output logic [CNT_W-1:0]  issued_41,
  output logic [15:0]       underruns_41,
  output logic              busy_41,
  output logic              done_41
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic [ADDR_W-1:0] adder_q, adder_d;
  logic              adder_valid_q, adder_valid_d;
  logic [CNT_W-1:0]  issued_q, issued_d;
  logic [15:0]       underruns_q, underruns_d;
  logic [ADDR_W:0]   mem_q [DEPTH];

  logic              full;
  logic              push;
  logic              pop;
  logic [ADDR_W:0]   rd_entry;

  always_comb begin
    full     = (occ_q == OCC_W'(DEPTH));
    push     = in_valid_41 && !full;
    // Pop decision uses registered occupancy only, so a same-cycle push never bypasses.
    pop      = (state_q == RUN) && !hold_41 && (occ_q != '0);
    rd_entry = mem_q[rd_ptr_q];

    state_d       = state_q;
    adder_d       = adder_q;
    adder_valid_d = 1'b0;
    issued_d      = issued_q;
    underruns_d   = underruns_q;

    case (state_q)
      IDLE, DONE: begin
        if (start_41) begin
          state_d     = RUN;
          issued_d    = '0;
          underruns_d = '0;
        end
      end
      RUN: begin
        if (pop) begin
          adder_d       = rd_entry[ADDR_W-1:0];
          adder_valid_d = 1'b1;
          if (issued_q != '1) issued_d = issued_q + CNT_W'(1);
          if (rd_entry[ADDR_W]) state_d = DONE;
        end else if (!hold_41 && (underruns_q != 16'hFFFF)) begin
          underruns_d = underruns_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk_41) begin
    if (!rst_41) begin
      state_q       <= IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      occ_q         <= '0;
      adder_q       <= '0;
      adder_valid_q <= 1'b0;
      issued_q      <= '0;
      underruns_q   <= '0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      occ_q         <= occ_d;
      adder_q       <= adder_d;
      adder_valid_q <= adder_valid_d;
      issued_q      <= issued_d;
      underruns_q   <= underruns_d;
    end
  end

  // Storage needs no reset: pointers and occupancy define which entries are live.
  always_ff @(posedge clk_41) begin
    if (rst_41 && push) mem_q[wr_ptr_q] <= {in_last_41, in_addr_41};
  end

  assign in_ready_41    = !full;
  assign adder_41       = adder_q;
  assign adder_valid_41 = adder_valid_q;
  assign issued_41      = issued_q;
  assign underruns_41   = underruns_q;
  assign busy_41        = (state_q == RUN);
  assign done_41        = (state_q == DONE);

endmodule

// File: tb/tb_trace_feeder.sv
// Self-checking bench for trace_feeder: a directed vector table, hand-written corner
// sequences and a randomized phase, all compared against a queue-based reference model.
module tb_trace_feeder;

  localparam int DEPTH = 16;

  logic        clk_41 = 1'b0;
  logic        rst_41 = 1'b0;
  logic [30:0] in_addr_41 = '0;
  logic        in_last_41 = 1'b0;
  logic        in_valid_41 = 1'b0;
  logic        in_ready_41;
  logic        start_41 = 1'b0;
  logic        hold_41 = 1'b0;
  logic [30:0] adder_41;
  logic        adder_valid_41;
  logic [30:0] issued_41;
  logic [15:0] underruns_41;
  logic        busy_41;
  logic        done_41;

  int total = 0;
  int bad   = 0;

  trace_feeder #(.ADDR_W(31), .DEPTH(DEPTH), .CNT_W(31)) dut (
    .clk_41(clk_41), .rst_41(rst_41),
    .in_addr_41(in_addr_41), .in_last_41(in_last_41),
    .in_valid_41(in_valid_41), .in_ready_41(in_ready_41),
    .start_41(start_41), .hold_41(hold_41),
    .adder_41(adder_41), .adder_valid_41(adder_valid_41),
    .issued_41(issued_41), .underruns_41(underruns_41),
    .busy_41(busy_41), .done_41(done_41)
  );

  always #5 clk_41 = ~clk_41;

  // Reference model: a plain queue of trace entries plus a run mode and counters.
  typedef struct packed {
    logic        last;
    logic [30:0] addr;
  } entry_t;

  entry_t      m_q[$];
  int          m_mode = 0;        // 0 idle, 1 running, 2 finished
  longint      m_issued = 0;
  longint      m_under = 0;
  logic [30:0] m_adder = '0;
  logic        m_valid = 1'b0;
  logic        m_accepted = 1'b0;

  task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelStep();
    int     pre_size;
    entry_t e;
    pre_size   = m_q.size();
    m_accepted = 1'b0;
    if (!rst_41) begin
      m_q.delete();
      m_mode   = 0;
      m_issued = 0;
      m_under  = 0;
      m_adder  = '0;
      m_valid  = 1'b0;
    end else begin
      m_accepted = in_valid_41 && (pre_size != DEPTH);
      m_valid    = 1'b0;
      if (m_mode != 1) begin
        if (start_41) begin
          m_mode   = 1;
          m_issued = 0;
          m_under  = 0;
        end
      end else if (!hold_41) begin
        if (pre_size > 0) begin
          e        = m_q.pop_front();
          m_adder  = e.addr;
          m_valid  = 1'b1;
          if (m_issued < 64'h7FFF_FFFF) m_issued++;
          if (e.last) m_mode = 2;
        end else if (m_under < 65535) begin
          m_under++;
        end
      end
      if (m_accepted) m_q.push_back({in_last_41, in_addr_41});
    end
  endtask

  task automatic checkOutput();
    checkVal("in_ready", 64'(in_ready_41), 64'(m_q.size() != DEPTH));
    checkVal("adder_valid", 64'(adder_valid_41), 64'(m_valid));
    checkVal("adder", 64'(adder_41), 64'(m_adder));
    checkVal("issued", 64'(issued_41), 64'(m_issued));
    checkVal("underruns", 64'(underruns_41), 64'(m_under));
    checkVal("busy", 64'(busy_41), 64'(m_mode == 1));
    checkVal("done", 64'(done_41), 64'(m_mode == 2));
  endtask

  task automatic applyStimulus();
    modelStep();
    @(posedge clk_41);
    #1;
    checkOutput();
  endtask

  task automatic runUntilDone(input int budget);
    int n = 0;
    while (m_mode != 2 && n < budget) begin
      applyStimulus();
      n++;
    end
    if (m_mode != 2) begin
      total++;
      bad++;
      $display("[TB] FAIL run_timeout: got no completion expected done within %0d cycles", budget);
    end
  endtask

  typedef struct {
    logic        rst_n, valid, last, start, hold;
    logic [30:0] addr;
    logic        exp_valid;
    logic [30:0] exp_adder;
    logic        exp_busy, exp_done, exp_ready;
    int          exp_issued;
  } vec_t;

  function automatic vec_t mk(input logic rst_n, input logic valid, input logic [30:0] addr,
                              input logic last, input logic start, input logic ev,
                              input logic [30:0] ea, input logic eb, input logic ed,
                              input int ei);
    vec_t v;
    v.rst_n = rst_n; v.valid = valid; v.addr = addr; v.last = last; v.start = start;
    v.hold = 1'b0; v.exp_valid = ev; v.exp_adder = ea; v.exp_busy = eb; v.exp_done = ed;
    v.exp_ready = 1'b1; v.exp_issued = ei;
    return v;
  endfunction

  vec_t vecs[11];

  initial begin
    int bubbles;

    // Reset, fill four addresses, replay them.
    vecs[0]  = mk(0, 0, 31'h000, 0, 0, 0, 31'h000, 0, 0, 0);
    vecs[1]  = mk(1, 1, 31'h000, 0, 0, 0, 31'h000, 0, 0, 0);
    vecs[2]  = mk(1, 1, 31'h020, 0, 0, 0, 31'h000, 0, 0, 0);
    vecs[3]  = mk(1, 1, 31'h040, 0, 0, 0, 31'h000, 0, 0, 0);
    vecs[4]  = mk(1, 1, 31'h060, 1, 0, 0, 31'h000, 0, 0, 0);
    vecs[5]  = mk(1, 0, 31'h000, 0, 1, 0, 31'h000, 1, 0, 0);
    vecs[6]  = mk(1, 0, 31'h000, 0, 0, 1, 31'h000, 1, 0, 1);
    vecs[7]  = mk(1, 0, 31'h000, 0, 0, 1, 31'h020, 1, 0, 2);
    vecs[8]  = mk(1, 0, 31'h000, 0, 0, 1, 31'h040, 1, 0, 3);
    vecs[9]  = mk(1, 0, 31'h000, 0, 0, 1, 31'h060, 0, 1, 4);
    vecs[10] = mk(1, 0, 31'h000, 0, 0, 0, 31'h060, 0, 1, 4);

    for (int i = 0; i < 11; i++) begin
      rst_41 = vecs[i].rst_n; in_valid_41 = vecs[i].valid; in_addr_41 = vecs[i].addr;
      in_last_41 = vecs[i].last; start_41 = vecs[i].start; hold_41 = vecs[i].hold;
      applyStimulus();
      checkVal("vec_valid", 64'(adder_valid_41), 64'(vecs[i].exp_valid));
      checkVal("vec_adder", 64'(adder_41), 64'(vecs[i].exp_adder));
      checkVal("vec_busy", 64'(busy_41), 64'(vecs[i].exp_busy));
      checkVal("vec_done", 64'(done_41), 64'(vecs[i].exp_done));
      checkVal("vec_ready", 64'(in_ready_41), 64'(vecs[i].exp_ready));
      checkVal("vec_issued", 64'(issued_41), 64'(vecs[i].exp_issued));
      checkVal("vec_underruns", 64'(underruns_41), 64'd0);
    end
    in_valid_41 = 0; start_41 = 0; in_last_41 = 0;

    // Full FIFO: 17 pushes without start, 17th held until space frees up.
    for (int i = 0; i < 17; i++) begin
      in_valid_41 = 1; in_addr_41 = 31'(32'h100 + i); in_last_41 = (i == 16);
      applyStimulus();
      if (i >= 15) checkVal("full_ready", 64'(in_ready_41), 64'd0);
    end
    start_41 = 1;
    applyStimulus();
    start_41 = 0;
    for (int n = 0; n < 5 && !m_accepted; n++) applyStimulus();
    checkVal("full_accept", 64'(m_accepted), 64'd1);
    in_valid_41 = 0; in_last_41 = 0;
    runUntilDone(40);
    checkVal("full_issued", 64'(issued_41), 64'd17);
    checkVal("full_last_addr", 64'(adder_41), 64'h110);

    // Underrun: start with an empty FIFO, then push a single last entry.
    start_41 = 1;
    applyStimulus();
    start_41 = 0;
    repeat (3) applyStimulus();
    checkVal("under_three", 64'(underruns_41), 64'd3);
    in_valid_41 = 1; in_addr_41 = 31'h1F00; in_last_41 = 1;
    applyStimulus();
    in_valid_41 = 0; in_last_41 = 0;
    runUntilDone(5);
    checkVal("under_count", 64'(underruns_41), 64'd4);
    checkVal("under_issued", 64'(issued_41), 64'd1);
    checkVal("under_addr", 64'(adder_41), 64'h1F00);

    // Hold: six entries, hold asserted for two cycles mid-replay.
    for (int i = 0; i < 6; i++) begin
      in_valid_41 = 1; in_addr_41 = 31'(32'h2000 + 4 * i); in_last_41 = (i == 5);
      applyStimulus();
    end
    in_valid_41 = 0; in_last_41 = 0;
    start_41 = 1;
    applyStimulus();
    start_41 = 0;
    bubbles = 0;
    for (int c = 0; c < 8; c++) begin
      hold_41 = (c == 2 || c == 3);
      applyStimulus();
      if (!adder_valid_41) bubbles++;
    end
    hold_41 = 0;
    checkVal("hold_bubbles", 64'(bubbles), 64'd2);
    checkVal("hold_issued", 64'(issued_41), 64'd6);
    checkVal("hold_underruns", 64'(underruns_41), 64'd0);
    checkVal("hold_done", 64'(done_41), 64'd1);

    // Pointer wrap: 40 addresses streamed with concurrent push and pop.
    start_41 = 1;
    applyStimulus();
    start_41 = 0;
    for (int i = 1; i <= 40; i++) begin
      in_valid_41 = 1; in_addr_41 = 31'(i * 8); in_last_41 = (i == 40);
      applyStimulus();
    end
    in_valid_41 = 0; in_last_41 = 0;
    runUntilDone(5);
    checkVal("wrap_issued", 64'(issued_41), 64'd40);
    checkVal("wrap_underruns", 64'(underruns_41), 64'd1);

    // Reset mid-run discards the FIFO and ignores start/push during reset.
    for (int i = 0; i < 5; i++) begin
      in_valid_41 = 1; in_addr_41 = 31'(32'h3000 + i); in_last_41 = 0;
      applyStimulus();
    end
    in_valid_41 = 0;
    start_41 = 1;
    applyStimulus();
    start_41 = 0;
    repeat (2) applyStimulus();
    rst_41 = 0; start_41 = 1; in_valid_41 = 1; in_addr_41 = 31'h3FFF;
    applyStimulus();
    checkVal("rst_busy", 64'(busy_41), 64'd0);
    checkVal("rst_valid", 64'(adder_valid_41), 64'd0);
    checkVal("rst_adder", 64'(adder_41), 64'd0);
    checkVal("rst_issued", 64'(issued_41), 64'd0);
    checkVal("rst_ready", 64'(in_ready_41), 64'd1);
    rst_41 = 1; start_41 = 0; in_valid_41 = 0;
    applyStimulus();
    checkVal("rst_idle", 64'(busy_41), 64'd0);
    start_41 = 1;
    applyStimulus();
    start_41 = 0;
    applyStimulus();
    checkVal("rst_fifo_empty", 64'(underruns_41), 64'd1);
    in_valid_41 = 1; in_addr_41 = 31'h4444; in_last_41 = 1;
    applyStimulus();
    in_valid_41 = 0; in_last_41 = 0;
    runUntilDone(5);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      rst_41      = ($urandom_range(0, 299) != 0);
      in_valid_41 = $urandom_range(0, 1);
      in_addr_41  = 31'($urandom());
      in_last_41  = ($urandom_range(0, 7) == 0);
      start_41    = ($urandom_range(0, 9) == 0);
      hold_41     = ($urandom_range(0, 3) == 0);
      applyStimulus();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
